// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the bridge-side width converters.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_downsizer_64to32.sv
// AHB-Lite 64-to-32 downsizer: splits aligned doubleword transfers into two
// word beats, passes narrower transfers through, stalls upstream until done.
module ahb_downsizer_64to32
  import ahb_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter bit          ErrOnMisalign = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 hsel_i,
  input  logic [AddrWidth-1:0] haddr_i,
  input  logic [2:0]           hsize_i,
  input  logic [1:0]           htrans_i,
  input  logic                 hwrite_i,
  input  logic [63:0]          hwdata_i,
  input  logic                 hready_i,
  output logic                 hreadyout_o,
  output logic                 hresp_o,
  output logic [63:0]          hrdata_o,
  output logic [AddrWidth-1:0] m_haddr_o,
  output logic [2:0]           m_hsize_o,
  output logic [1:0]           m_htrans_o,
  output logic                 m_hwrite_o,
  output logic [31:0]          m_hwdata_o,
  input  logic                 m_hready_i,
  input  logic                 m_hresp_i,
  input  logic [31:0]          m_hrdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_A0, ST_D0, ST_A1, ST_D1, ST_RESP, ST_ERR1, ST_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic                   write_q, write_d;
  logic                   two_beat_q, two_beat_d;
  logic [63:0]            rdata_q, rdata_d;

  logic accept, illegal, aligned64, start;

  assign accept    = hsel_i & htrans_i[1] & hready_i;
  assign aligned64 = (hsize_i == SIZE_D) && (haddr_i[2:0] == 3'b000);
  assign illegal   = (hsize_i > SIZE_D) ||
                     ((hsize_i == SIZE_D) && (haddr_i[2:0] != 3'b000) && ErrOnMisalign);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      two_beat_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      two_beat_q <= two_beat_d;
      rdata_q    <= rdata_d;
    end
  end

  assign hrdata_o = rdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    two_beat_d  = two_beat_q;
    rdata_d     = rdata_q;
    start       = 1'b0;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    m_htrans_o  = HTRANS_IDLE;
    m_haddr_o   = '0;
    m_hsize_o   = '0;
    m_hwrite_o  = 1'b0;
    m_hwdata_o  = '0;

    unique case (state_q)
      ST_IDLE: start = 1'b1;
      ST_A0: begin
        hreadyout_o = 1'b0;
        m_htrans_o  = HTRANS_NONSEQ;
        m_haddr_o   = two_beat_q ? (addr_q & ~AddrWidth'(4)) : addr_q;
        m_hsize_o   = (size_q > SIZE_W) ? SIZE_W : size_q;
        m_hwrite_o  = write_q;
        if (m_hready_i) state_d = ST_D0;
      end
      ST_D0: begin
        hreadyout_o = 1'b0;
        m_hwdata_o  = (two_beat_q || !addr_q[2]) ? hwdata_i[31:0] : hwdata_i[63:32];
        if (m_hready_i) begin
          if (m_hresp_i) begin
            state_d = ST_ERR1;
          end else begin
            // Narrow reads replicate the word so either upstream lane is valid.
            if (!write_q)
              rdata_d = two_beat_q ? {rdata_q[63:32], m_hrdata_i} : {m_hrdata_i, m_hrdata_i};
            state_d = two_beat_q ? ST_A1 : ST_RESP;
          end
        end
      end
      ST_A1: begin
        hreadyout_o = 1'b0;
        m_htrans_o  = HTRANS_NONSEQ;
        m_haddr_o   = addr_q | AddrWidth'(4);
        m_hsize_o   = SIZE_W;
        m_hwrite_o  = write_q;
        if (m_hready_i) state_d = ST_D1;
      end
      ST_D1: begin
        hreadyout_o = 1'b0;
        m_hwdata_o  = hwdata_i[63:32];
        if (m_hready_i) begin
          if (m_hresp_i) begin
            state_d = ST_ERR1;
          end else begin
            if (!write_q) rdata_d = {m_hrdata_i, rdata_q[31:0]};
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: start = 1'b1;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_o = HRESP_ERROR;
        start   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // IDLE, RESP and ERR2 all end an upstream data phase and may take a new address.
    if (start) begin
      state_d = ST_IDLE;
      if (accept) begin
        addr_d     = haddr_i;
        size_d     = hsize_i;
        write_d    = hwrite_i;
        two_beat_d = aligned64;
        state_d    = illegal ? ST_ERR1 : ST_A0;
      end
    end
  end

endmodule

// File: doc/ahb_downsizer_64to32.md
Name: ahb_downsizer_64to32

Overview:
AHB-Lite width converter between the 64-bit AXI-to-AHB bridge output and 32-bit-register peripherals such as the UART.
- Turns each 8-byte-aligned 64-bit transfer into two sequential 32-bit downstream transfers, low word then high word.
- Passes 8/16/32-bit transfers through as a single beat on the correct data lane.
- Stalls the upstream side with hreadyout_o until the downstream side completes.

Parameters:
- AddrWidth, 32, address width on both sides.
- ErrOnMisalign, 1, if 1 a 64-bit transfer with haddr[2:0]!=0 gets an ERROR response and no downstream access; if 0 it is issued as a single 32-bit beat.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- hsel_i  in  1  upstream select
- haddr_i  in  AddrWidth  upstream address
- hsize_i  in  3  upstream size
- htrans_i  in  2  upstream transfer type
- hwrite_i  in  1  upstream write
- hwdata_i  in  64  upstream write data
- hready_i  in  1  upstream bus ready
- hreadyout_o  out  1  upstream ready
- hresp_o  out  1  upstream response (1 = ERROR)
- hrdata_o  out  64  upstream read data
- m_haddr_o  out  AddrWidth  downstream address
- m_hsize_o  out  3  downstream size
- m_htrans_o  out  2  downstream transfer type
- m_hwrite_o  out  1  downstream write
- m_hwdata_o  out  32  downstream write data
- m_hready_i  in  1  downstream ready
- m_hresp_i  in  1  downstream response
- m_hrdata_i  in  32  downstream read data

Behaviour:
- Reset values: hreadyout_o=1, hresp_o=0, hrdata_o=0, m_htrans_o=IDLE, m_haddr_o=0, m_hsize_o=0, m_hwrite_o=0, m_hwdata_o=0. State goes to IDLE.
- Reset mid-transfer aborts immediately. Partially assembled read data is discarded.
- Accept condition: hsel_i & htrans_i[1] & hready_i in IDLE. On accept, register haddr, hsize, hwrite and a two_beat flag (hsize==3 and aligned).
- FSM states: IDLE, A0, D0, A1, D1, RESP, ERR1, ERR2.
  - IDLE: on accept go to A0. If the size is illegal (hsize>3, or misaligned 64-bit with ErrOnMisalign=1), go to ERR1 instead.
  - A0: m_htrans_o=NONSEQ, m_haddr_o=registered addr (two_beat: addr with [2]=0), m_hsize_o=min(hsize,2). Advance to D0 when m_hready_i=1.
  - D0: m_htrans_o=IDLE. Wait for m_hready_i=1.
    - m_hresp_i=1 goes to ERR1; the second beat is never issued.
    - Otherwise capture m_hrdata_i into the lane selected by addr[2] (low lane for two_beat), then go to A1 if two_beat, else RESP.
  - A1: address addr|4, size 2, NONSEQ. Advance to D1 on m_hready_i.
  - D1: capture m_hrdata_i into hrdata[63:32]. An error goes to ERR1; otherwise go to RESP.
  - RESP: hreadyout_o=1, hresp_o=0, hrdata_o valid for this cycle. A new accept in the same cycle goes to A0 or ERR1; otherwise go to IDLE.
  - ERR1: hreadyout_o=0, hresp_o=1. Always go to ERR2.
  - ERR2: hreadyout_o=1, hresp_o=1. Then IDLE; back-to-back accept allowed as in RESP.
- hreadyout_o is 0 in A0, D0, A1, D1 and ERR1; it is 1 in IDLE, RESP and ERR2.
- Write data: the upstream hwdata_i is stable while stalled and is muxed combinationally.
  - D0 drives hwdata_i[31:0] for two_beat, otherwise the addr[2]-selected half.
  - D1 drives hwdata_i[63:32].
- Latency with zero-wait downstream:
  - 64-bit transfer: 4 upstream wait states.
  - 32-bit or narrower: 2 wait states.
  - Each downstream wait cycle adds one.
- Upstream htrans IDLE/BUSY and hsel_i=0 are ignored, with zero-wait OKAY.
- Narrow reads return the 32-bit word replicated on both halves of hrdata_o.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - hsize constants SIZE_B/H/W/D
  - HRESP_OKAY/ERROR
- The FSM state enum stays local to the module.
- No sub-module is natural; the block is a single FSM with datapath registers.

Test Plan:
- 64-bit read at 0x1000; downstream returns 0x11111111@0x1000 and 0x22222222@0x1004 -> two NONSEQ beats of size 2, hrdata_o=0x22222222_11111111, 4 wait states.
- 32-bit write at 0x1004 with hwdata 0xAAAABBBB_CCCCDDDD -> single beat at 0x1004, m_hwdata_o=0xAAAABBBB, 2 wait states.
- 64-bit write at 0x2000 with m_hresp_i=1 on the first beat -> no beat at 0x2004, upstream sees ERR1 then ERR2 (hreadyout 0 then 1, hresp_o=1).
- 64-bit read at 0x1004 (ErrOnMisalign=1) -> m_htrans_o stays IDLE, two-cycle ERROR. hsize=4 behaves the same.
- 64-bit read with m_hready_i low 3 cycles in each data phase -> 10 upstream wait states, data correct; back-to-back second read accepted in the RESP cycle.
- rst_i asserted during D0 of a 64-bit read -> outputs return to reset values immediately; the next read completes normally.
